// File: rtl/apb_master_module.sv
// APB master: takes one command at a time from a sequencer, runs a single
// SETUP/ACCESS transfer on the APB bus and returns a one-cycle response pulse.
// An ACCESS phase that waits too long for pready_i ends with a timeout error.
module apb_master_module #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BUS_WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  localparam int unsigned MAX_DIM       = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,        // active-high, synchronous
  // Command side
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
  input  logic [MAX_DIM-1:0]    cmd_strb_i,
  // Response side
  output logic                  rsp_valid_o,
  output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  // APB master
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  // Slave calculation in progress
  input  logic                  busy_i
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; the expiring cycle exits ACCESS.
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [BUS_WIDTH-1:0]  pwdata_q, pwdata_d;
  logic [MAX_DIM-1:0]    pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  cmd_ready;

  // Ready is a decode of the registered state, blocked by busy_i and reset.
  assign cmd_ready = (state_q == StIdle) && !busy_i && !rst_ni;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && cmd_ready) begin
          state_d   = StSetup;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write_i;
          paddr_d   = cmd_addr_i;
          // Reads never drive data or strobes.
          pwdata_d  = cmd_write_i ? cmd_wdata_i : '0;
          pstrb_d   = cmd_write_i ? cmd_strb_i : '0;
        end
      end
      StSetup: begin
        state_d   = StAccess;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      StAccess: begin
        if (pready_i) begin
          // Completion wins over a timeout expiring in the same cycle.
          state_d       = StIdle;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata_i;
          rsp_err_d     = pslverr_i;
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          state_d       = StIdle;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = cmd_ready;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pstrb_o       = pstrb_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: doc/apb_master_module.md
APB_MASTER_MODULE -- requirements
Module: apb_master_module

Interface
REQ-001 Parameter DATA_WIDTH, default 8, matrix element width in bits.
REQ-002 Parameter BUS_WIDTH, default 16, APB data bus width in bits.
REQ-003 Parameter ADDR_WIDTH, default 32, APB address width in bits.
REQ-004 Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase cycles waited for pready_i.
REQ-005 Derived constant MAX_DIM = BUS_WIDTH/DATA_WIDTH SHALL set the strobe width.
REQ-006 clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-007 rst_ni  in  1  reset, synchronous and active-high: sampled only at rising clk_i, asserted when 1.
REQ-008 cmd_valid_i  in  1  command request from the sequencer.
REQ-009 cmd_ready_o  out  1  module can accept a command this cycle.
REQ-010 cmd_write_i  in  1  1 = APB write, 0 = APB read.
REQ-011 cmd_addr_i  in  ADDR_WIDTH  target address.
REQ-012 cmd_wdata_i  in  BUS_WIDTH  write data.
REQ-013 cmd_strb_i  in  MAX_DIM  write byte-lane strobes.
REQ-014 rsp_valid_o  out  1  one-cycle response pulse.
REQ-015 rsp_rdata_o  out  BUS_WIDTH  read data captured from prdata_i (0 for writes).
REQ-016 rsp_err_o  out  1  transfer ended with pslverr_i or timeout.
REQ-017 rsp_timeout_o  out  1  transfer ended by timeout.
REQ-018 psel_o, penable_o, pwrite_o  out  1 each  APB control outputs to the matmul slave.
REQ-019 paddr_o  out  ADDR_WIDTH; pwdata_o  out  BUS_WIDTH; pstrb_o  out  MAX_DIM  APB payload outputs.
REQ-020 pready_i, pslverr_i  in  1 each; prdata_i  in  BUS_WIDTH  APB slave responses.
REQ-021 busy_i  in  1  matmul calculation in progress; gates command acceptance.

Function
REQ-022 FSM states SHALL be IDLE, SETUP, ACCESS; all outputs registered.
REQ-023 cmd_ready_o SHALL be 1 only in IDLE with busy_i = 0.
REQ-024 Acceptance SHALL occur on a rising edge where cmd_valid_i and cmd_ready_o are both 1: capture write, addr, wdata, strb; IDLE->SETUP.
REQ-025 SETUP (exactly one cycle): psel_o=1, penable_o=0, payload driven from captured values; SETUP->ACCESS unconditionally.
REQ-026 ACCESS: psel_o=1, penable_o=1; paddr_o, pwrite_o, pwdata_o, pstrb_o SHALL not change during SETUP and ACCESS.
REQ-027 For reads, pstrb_o SHALL be all-zero and pwdata_o SHALL be 0.
REQ-028 ACCESS->IDLE on the first edge with pready_i=1: capture prdata_i (reads only) and pslverr_i, and assert rsp_valid_o in the following cycle.
REQ-029 Timeout counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready_i=0; when it reaches TIMEOUT_CYCLES, ACCESS->IDLE with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-030 Timeout SHALL NOT fire if pready_i=1 in the same cycle the counter reaches TIMEOUT_CYCLES; the pready_i completion wins.
REQ-031 rsp_valid_o SHALL be a single-cycle pulse with no backpressure; rsp_rdata_o, rsp_err_o and rsp_timeout_o SHALL hold until the next response.
REQ-032 Latency: accept at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2; with zero wait states, rsp_valid_o=1 and cmd_ready_o=1 in cycle N+3; sustained throughput is one transfer per 3 cycles.
REQ-033 If busy_i rises after a command is accepted, the in-flight transfer SHALL complete normally; busy_i only blocks new acceptance.
REQ-034 In IDLE, psel_o and penable_o SHALL be 0; payload outputs hold their last values.

Reset
REQ-035 While rst_ni=1 at an edge: state=IDLE, counter=0, and psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o all become 0.
REQ-036 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid_o pulse; psel_o=0 from the cycle after the reset edge.
REQ-037 cmd_ready_o SHALL be 0 during reset and follow REQ-023 from the first cycle after reset deasserts.

Verification
REQ-038 Write addr=0x0, wdata=0x0102, strb=2'b11, pready_i tied 1 -> SETUP/ACCESS each one cycle, pstrb_o=2'b11, rsp_valid_o at N+3, rsp_err_o=0.
REQ-039 Read addr=0x10, prdata_i=0xA5C3, pready_i delayed 2 cycles -> ACCESS lasts 3 cycles, pstrb_o=0, rsp_rdata_o=0xA5C3, rsp_err_o=0.
REQ-040 Write with pslverr_i=1 on the pready_i cycle -> rsp_err_o=1, rsp_timeout_o=0.
REQ-041 pready_i held 0 with TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then psel_o=0, rsp_err_o=1, rsp_timeout_o=1; a second run with pready_i=1 on the 16th cycle -> normal completion, rsp_timeout_o=0.
REQ-042 busy_i=1 with cmd_valid_i=1 -> cmd_ready_o=0 and no psel_o; on busy_i falling, accept next cycle; back-to-back commands -> one transfer per 3 cycles.
REQ-043 rst_ni=1 asserted during ACCESS -> psel_o=penable_o=0 next cycle, no rsp_valid_o pulse, cmd_ready_o=1 once rst_ni=0 and busy_i=0.
